// File: rtl/blit_pkg.sv
// Shared widths and state/grant encodings for the blitter memory arbiter.
package blit_pkg;
    localparam int MEM_AW = 24;
    localparam int MEM_DW = 16;

    typedef enum logic {ST_IDLE, ST_WAIT} arb_state_t;
    typedef enum logic {GNT_CPU, GNT_VID} gnt_t;
endpackage

// File: rtl/blit_reqlatch.sv
// Per-port request latch: pending flag plus payload capture.
// A request seen while this port is pending or outstanding is dropped.
module blit_reqlatch
    import blit_pkg::*;
(
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic [MEM_AW-1:0] addr,
    input  logic [MEM_DW-1:0] wdata,
    input  logic [1:0]        wstrb,
    input  logic              we,
    input  logic              busy,
    input  logic              take,
    output logic              pending,
    output logic [MEM_AW-1:0] pend_addr,
    output logic [MEM_DW-1:0] pend_wdata,
    output logic [1:0]        pend_wstrb,
    output logic              pend_we
);
    logic accept;

    assign accept = req && !pending && !busy;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending <= 1'b0;
        end else if (take) begin
            pending <= 1'b0;
        end else if (accept) begin
            pending <= 1'b1;
        end
    end

    // Payload only matters while pending, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_addr  <= addr;
            pend_wdata <= wdata;
            pend_wstrb <= wstrb;
            pend_we    <= we;
        end
    end
endmodule

// File: rtl/blit_memarb.sv
// Arbitrates the 16-bit system memory port between the CPU bridge and the
// display fetch engine; video has priority, bounded by a CPU anti-starvation streak.
module blit_memarb
    import blit_pkg::*;
#(
    parameter logic [MEM_AW-1:0] MEMTOP  = 24'h100000,
    parameter int unsigned       VID_MAX = 4,
    parameter int unsigned       TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cpu_req,
    input  logic [MEM_AW-1:0] cpu_addr,
    input  logic [MEM_DW-1:0] cpu_wdata,
    input  logic [1:0]        cpu_wstrb,
    input  logic              cpu_we,
    output logic              cpu_ack,
    output logic [MEM_DW-1:0] cpu_rdata,
    output logic              cpu_err,
    input  logic              vid_req,
    input  logic [MEM_AW-1:0] vid_addr,
    output logic              vid_ack,
    output logic [MEM_DW-1:0] vid_rdata,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [MEM_DW-1:0] mem_wdata,
    output logic [1:0]        mem_wstrb,
    output logic              mem_we,
    input  logic              mem_ack,
    input  logic [MEM_DW-1:0] mem_rdata,
    input  logic              mem_err
);
    localparam logic [2:0] STREAK_MAX = 3'(VID_MAX);
    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);

    arb_state_t        state, state_n;
    gnt_t              gnt;
    logic              cool;
    logic [7:0]        cnt;
    logic [2:0]        streak;

    logic              cpu_pend, vid_pend;
    logic [MEM_AW-1:0] cpu_paddr, vid_paddr;
    logic [MEM_DW-1:0] cpu_pwdata, vid_pwdata;
    logic [1:0]        cpu_pwstrb, vid_pwstrb;
    logic              cpu_pwe, vid_pwe;

    logic              pick_cpu, grant, oor, finish, tmo;
    logic [MEM_AW-1:0] sel_addr;

    blit_reqlatch u_cpu_latch (
        .clk        (clk),
        .rstn       (rstn),
        .req        (cpu_req),
        .addr       (cpu_addr),
        .wdata      (cpu_wdata),
        .wstrb      (cpu_wstrb),
        .we         (cpu_we),
        .busy       (state == ST_WAIT && gnt == GNT_CPU),
        .take       (grant && pick_cpu),
        .pending    (cpu_pend),
        .pend_addr  (cpu_paddr),
        .pend_wdata (cpu_pwdata),
        .pend_wstrb (cpu_pwstrb),
        .pend_we    (cpu_pwe)
    );

    // Video is read-only with full-word strobes.
    blit_reqlatch u_vid_latch (
        .clk        (clk),
        .rstn       (rstn),
        .req        (vid_req),
        .addr       (vid_addr),
        .wdata      ({MEM_DW{1'b0}}),
        .wstrb      (2'b11),
        .we         (1'b0),
        .busy       (state == ST_WAIT && gnt == GNT_VID),
        .take       (grant && !pick_cpu),
        .pending    (vid_pend),
        .pend_addr  (vid_paddr),
        .pend_wdata (vid_pwdata),
        .pend_wstrb (vid_pwstrb),
        .pend_we    (vid_pwe)
    );

    // cool blocks arbitration for the single cycle after a WAIT completes,
    // giving the port that just got its ack a chance to re-request.
    always_comb begin
        state_n  = state;
        grant    = 1'b0;
        finish   = 1'b0;
        tmo      = 1'b0;
        pick_cpu = cpu_pend && (!vid_pend || streak == STREAK_MAX);
        sel_addr = pick_cpu ? cpu_paddr : vid_paddr;
        oor      = sel_addr >= MEMTOP;
        case (state)
            ST_IDLE: begin
                if (!cool && (cpu_pend || vid_pend)) begin
                    grant = 1'b1;
                    if (!oor) state_n = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_ack || cnt == TMO_LAST) begin
                    finish  = 1'b1;
                    tmo     = !mem_ack;
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= ST_IDLE;
            gnt    <= GNT_CPU;
            cool   <= 1'b0;
            cnt    <= '0;
            streak <= '0;
        end else begin
            state <= state_n;
            cool  <= finish;
            if (grant) begin
                cnt <= '0;
                gnt <= pick_cpu ? GNT_CPU : GNT_VID;
                if (pick_cpu || !cpu_pend) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 3'd1;
                end
            end else if (state == ST_WAIT) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            mem_we    <= 1'b0;
            cpu_ack   <= 1'b0;
            cpu_rdata <= '0;
            cpu_err   <= 1'b0;
            vid_ack   <= 1'b0;
            vid_rdata <= '0;
        end else begin
            mem_req <= 1'b0;
            cpu_ack <= 1'b0;
            vid_ack <= 1'b0;
            if (grant && !oor) begin
                mem_req   <= 1'b1;
                mem_addr  <= sel_addr;
                mem_wdata <= pick_cpu ? cpu_pwdata : vid_pwdata;
                mem_wstrb <= pick_cpu ? cpu_pwstrb : vid_pwstrb;
                mem_we    <= pick_cpu ? cpu_pwe    : vid_pwe;
            end
            if (grant && oor && pick_cpu) begin
                cpu_ack   <= 1'b1;
                cpu_err   <= 1'b1;
                cpu_rdata <= '0;
            end
            if (grant && oor && !pick_cpu) begin
                vid_ack   <= 1'b1;
                vid_rdata <= '0;
            end
            if (finish && gnt == GNT_CPU) begin
                cpu_ack   <= 1'b1;
                cpu_rdata <= tmo ? '0 : mem_rdata;
                cpu_err   <= tmo || mem_err;
            end
            if (finish && gnt == GNT_VID) begin
                vid_ack   <= 1'b1;
                vid_rdata <= (tmo || mem_err) ? '0 : mem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_blit_memarb.sv
// Directed and randomized checks of blit_memarb against a transaction-level model.
module tb_blit_memarb;
    localparam logic [23:0] MEMTOP  = 24'h100000;
    localparam int          VID_MAX = 4;
    localparam int          TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cpu_req = 1'b0;
    logic [23:0] cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic [1:0]  cpu_wstrb = '0;
    logic        cpu_we = 1'b0;
    logic        cpu_ack;
    logic [15:0] cpu_rdata;
    logic        cpu_err;
    logic        vid_req = 1'b0;
    logic [23:0] vid_addr = '0;
    logic        vid_ack;
    logic [15:0] vid_rdata;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [1:0]  mem_wstrb;
    logic        mem_we;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_err = 1'b0;

    blit_memarb #(.MEMTOP(MEMTOP), .VID_MAX(VID_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wstrb(cpu_wstrb), .cpu_we(cpu_we), .cpu_ack(cpu_ack),
        .cpu_rdata(cpu_rdata), .cpu_err(cpu_err),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_we(mem_we), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;

    // memory responder
    bit          auto_mem = 0;
    int          lat_max = 1;
    int          err_pct = 0;
    int          ack_at = -1;
    logic [15:0] resp_data;
    logic        resp_err;

    // transaction-level scoreboard for the randomized phase
    bit          rnd_on = 0;
    bit          cpu_out = 0, cpu_granted = 0, cpu_oor = 0;
    logic [23:0] cpu_e_addr;
    logic [15:0] cpu_e_wdata;
    logic [1:0]  cpu_e_wstrb;
    logic        cpu_e_we;
    logic [15:0] cpu_r_data;
    logic        cpu_r_err;
    int          cpu_req_cyc = 0;
    bit          vid_out = 0, vid_granted = 0, vid_oor = 0;
    logic [23:0] vid_e_addr;
    logic [15:0] vid_r_data;
    int          vid_run = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_mem_req"},   32'(mem_req),   0);
        check({tag, "_mem_addr"},  32'(mem_addr),  0);
        check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, "_mem_ctl"},   32'({mem_wstrb, mem_we}), 0);
        check({tag, "_cpu_out"},   32'({cpu_ack, cpu_err, cpu_rdata}), 0);
        check({tag, "_vid_out"},   32'({vid_ack, vid_rdata}), 0);
    endtask

    function automatic bit pend_window();
        return cpu_out && !cpu_granted && (cyc >= cpu_req_cyc + 2);
    endfunction

    task automatic monitor();
        if (mem_req) begin
            if (mem_addr < 24'h080000) begin
                check("rnd_cpu_grant_legal", 32'(cpu_out && !cpu_granted && !cpu_oor), 1);
                check("rnd_cpu_addr",  32'(mem_addr),  32'(cpu_e_addr));
                check("rnd_cpu_wdata", 32'(mem_wdata), 32'(cpu_e_wdata));
                check("rnd_cpu_ctl",   32'({mem_wstrb, mem_we}), 32'({cpu_e_wstrb, cpu_e_we}));
                check("rnd_streak_bound", 32'(vid_run <= VID_MAX), 1);
                vid_run = 0;
                cpu_granted = 1;
                cpu_r_data = resp_data;
                cpu_r_err = resp_err;
            end else begin
                check("rnd_vid_grant_legal", 32'(vid_out && !vid_granted && !vid_oor), 1);
                check("rnd_vid_addr", 32'(mem_addr), 32'(vid_e_addr));
                check("rnd_vid_ctl",  32'({mem_wstrb, mem_we}), 32'h6);
                if (pend_window()) vid_run++;
                vid_granted = 1;
                vid_r_data = resp_err ? 16'h0 : resp_data;
            end
        end
        if (cpu_ack) begin
            check("rnd_cpu_ack_expected", 32'(cpu_out), 1);
            if (cpu_oor) begin
                check("rnd_cpu_oor_resp", 32'({cpu_err, cpu_rdata}), 32'h10000);
                check("rnd_streak_bound", 32'(vid_run <= VID_MAX), 1);
                vid_run = 0;
            end else begin
                check("rnd_cpu_ack_after_grant", 32'(cpu_granted), 1);
                check("rnd_cpu_resp", 32'({cpu_err, cpu_rdata}), 32'({cpu_r_err, cpu_r_data}));
            end
            cpu_out = 0;
        end
        if (vid_ack) begin
            check("rnd_vid_ack_expected", 32'(vid_out), 1);
            if (vid_oor) begin
                check("rnd_vid_oor_resp", 32'(vid_rdata), 0);
                if (pend_window()) vid_run++;
            end else begin
                check("rnd_vid_ack_after_grant", 32'(vid_granted), 1);
                check("rnd_vid_resp", 32'(vid_rdata), 32'(vid_r_data));
            end
            vid_out = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        cpu_req = 0;
        vid_req = 0;
        mem_ack = 0;
        mem_err = 0;
        mem_rdata = 16'hDEAD ^ 16'(cyc);
        if (auto_mem) begin
            if (mem_req) begin
                ack_at = cyc + int'($urandom_range(1, lat_max));
                resp_data = mem_addr[15:0] ^ 16'h5A5A;
                resp_err = (err_pct != 0) && (int'($urandom_range(0, 99)) < err_pct);
            end else if (cyc == ack_at) begin
                mem_ack = 1;
                mem_rdata = resp_data;
                mem_err = resp_err;
                ack_at = -1;
            end
        end
        if (rnd_on) monitor();
    endtask

    task automatic wait_mem_req(input string tag, input int budget);
        int k = 0;
        while (!mem_req && k < budget) begin
            step();
            k++;
        end
        check({tag, "_mem_req_in_time"}, 32'(mem_req), 1);
    endtask

    task automatic issue_cpu();
        logic [31:0] r = $urandom;
        cpu_oor = ($urandom_range(0, 7) == 0);
        cpu_e_addr = cpu_oor ? (24'h800000 | r[23:0]) : (r[23:0] & 24'h07FFFE);
        cpu_e_wdata = 16'($urandom);
        cpu_e_wstrb = 2'($urandom_range(1, 3));
        cpu_e_we = 1'($urandom);
        cpu_out = 1;
        cpu_granted = 0;
        cpu_req_cyc = cyc;
        cpu_req = 1;
        cpu_addr = cpu_e_addr;
        cpu_wdata = cpu_e_wdata;
        cpu_wstrb = cpu_e_wstrb;
        cpu_we = cpu_e_we;
    endtask

    task automatic issue_vid();
        logic [31:0] r = $urandom;
        vid_oor = ($urandom_range(0, 7) == 0);
        vid_e_addr = vid_oor ? (24'hF00000 | r[23:0]) : (24'h080000 | (r[23:0] & 24'h07FFFE));
        vid_out = 1;
        vid_granted = 0;
        vid_req = 1;
        vid_addr = vid_e_addr;
    endtask

    int t0;
    int vg;
    int round;
    int v_at_cpu[2];

    initial begin
        // reset
        repeat (3) step();
        check_zero_outputs("reset");
        rstn = 1;
        repeat (3) step();

        // single CPU write
        t0 = cyc;
        cpu_addr = 24'h000100; cpu_wdata = 16'hBEEF; cpu_wstrb = 2'b10; cpu_we = 1; cpu_req = 1;
        step();
        check("wr_no_early_mem_req", 32'(mem_req), 0);
        step();
        check("wr_mem_req_at_n2", 32'(mem_req), 1);
        check("wr_mem_addr", 32'(mem_addr), 32'h000100);
        check("wr_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        check("wr_mem_ctl", 32'({mem_wstrb, mem_we}), 32'h5);
        step();
        check("wr_mem_req_pulse", 32'(mem_req), 0);
        check("wr_no_early_ack", 32'(cpu_ack), 0);
        mem_ack = 1; mem_rdata = 16'h0000;
        step();
        check("wr_cpu_ack_at_m1", 32'({cpu_ack, cpu_err}), 32'h2);
        check("wr_cycle", 32'(cyc - t0), 4);
        step();
        check("wr_cpu_ack_pulse", 32'(cpu_ack), 0);
        repeat (2) step();

        // video read
        vid_addr = 24'h004000; vid_req = 1;
        step();
        step();
        check("vid_mem_req", 32'(mem_req), 1);
        check("vid_mem_addr", 32'(mem_addr), 32'h004000);
        check("vid_mem_ctl", 32'({mem_wstrb, mem_we}), 32'h6);
        step();
        mem_ack = 1; mem_rdata = 16'h1234;
        step();
        check("vid_ack_rdata", 32'({vid_ack, vid_rdata}), 32'h11234);
        check("vid_no_cpu_ack", 32'(cpu_ack), 0);
        step();
        check("vid_rdata_stable", 32'({vid_ack, vid_rdata}), 32'h01234);
        repeat (2) step();

        // contention: video re-requests on every ack while the CPU waits
        auto_mem = 1; lat_max = 1; err_pct = 0;
        vg = 0; round = 0; v_at_cpu[0] = -1; v_at_cpu[1] = -1;
        cpu_addr = 24'h000200; cpu_we = 0; cpu_wstrb = 2'b11; cpu_req = 1;
        vid_addr = 24'h004000; vid_req = 1;
        for (int k = 0; k < 400 && round < 2; k++) begin
            step();
            if (mem_req) begin
                if (mem_addr == 24'h000200) begin
                    v_at_cpu[round] = vg;
                    vg = 0;
                end else begin
                    vg++;
                end
            end
            if (cpu_ack) begin
                round++;
                if (round < 2) cpu_req = 1;
            end
            if (vid_ack && round < 2) vid_req = 1;
        end
        check("cont_rounds_done", 32'(round), 2);
        check("cont_vid_grants_first", 32'(v_at_cpu[0]), VID_MAX);
        check("cont_vid_grants_after_reset", 32'(v_at_cpu[1]), VID_MAX);
        repeat (12) step();
        auto_mem = 0;

        // out-of-range
        t0 = cyc;
        cpu_addr = 24'h100000; cpu_we = 0; cpu_req = 1;
        step();
        check("oor_cpu_not_early", 32'({cpu_ack, mem_req}), 0);
        step();
        check("oor_cpu_resp", 32'({cpu_ack, cpu_err, cpu_rdata}), 32'h30000);
        check("oor_cpu_no_mem_req", 32'(mem_req), 0);
        vid_addr = 24'hFFFFFE; vid_req = 1;
        step();
        step();
        check("oor_vid_resp", 32'({vid_ack, vid_rdata}), 32'h10000);
        check("oor_vid_no_mem_req", 32'(mem_req), 0);
        repeat (2) step();

        // timeout
        cpu_addr = 24'h000400; cpu_we = 0; cpu_wstrb = 2'b11; cpu_req = 1;
        step();
        step();
        check("tmo_mem_req", 32'(mem_req), 1);
        for (int k = 1; k <= TIMEOUT - 1; k++) begin
            step();
            if (k == 1) begin
                vid_addr = 24'h006000;
                vid_req = 1;
            end
        end
        check("tmo_not_early", 32'({cpu_ack, vid_ack, mem_req}), 0);
        step();
        check("tmo_cpu_err_ack", 32'({cpu_ack, cpu_err}), 32'h3);
        wait_mem_req("tmo_next", 6);
        check("tmo_next_addr", 32'(mem_addr), 32'h006000);
        step();
        mem_ack = 1; mem_rdata = 16'h0BAD; mem_err = 1;
        step();
        check("tmo_vid_err_rdata", 32'({vid_ack, vid_rdata}), 32'h10000);
        repeat (2) step();

        // reset mid-WAIT
        cpu_addr = 24'h000800; cpu_req = 1;
        wait_mem_req("rstw", 6);
        repeat (2) step();
        rstn = 0;
        step();
        check_zero_outputs("rstw_during");
        step();
        rstn = 1;
        step();
        mem_ack = 1; mem_rdata = 16'hCAFE;
        step();
        check("rstw_late_ack_ignored", 32'({cpu_ack, vid_ack, mem_req}), 0);
        repeat (3) step();
        check("rstw_still_quiet", 32'({cpu_ack, vid_ack, mem_req}), 0);
        cpu_addr = 24'h000A00; cpu_req = 1;
        wait_mem_req("rstw_fresh", 6);
        check("rstw_fresh_addr", 32'(mem_addr), 32'h000A00);
        step();
        mem_ack = 1; mem_rdata = 16'h7777;
        step();
        check("rstw_fresh_resp", 32'({cpu_ack, cpu_err, cpu_rdata}), 32'h27777);
        repeat (2) step();

        // randomized traffic against the scoreboard
        auto_mem = 1; lat_max = 4; err_pct = 15; rnd_on = 1;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (!cpu_out) begin
                if ($urandom_range(0, 3) == 0) issue_cpu();
            end else if ($urandom_range(0, 15) == 0) begin
                cpu_req = 1; cpu_addr = 24'($urandom); cpu_wdata = 16'($urandom); cpu_we = 1;
            end
            if (!vid_out) begin
                if ($urandom_range(0, 1) == 0) issue_vid();
            end else if ($urandom_range(0, 15) == 0) begin
                vid_req = 1; vid_addr = 24'($urandom);
            end
        end
        for (int k = 0; k < 100 && (cpu_out || vid_out); k++) step();
        check("rnd_drained", 32'({cpu_out, vid_out}), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
